ex_mem_stage: RTL and testbench

//  Execute stage plus EX/MEM pipeline register; consumes the ID/EX buffer outputs.

---
 rtl/ex_pkg.sv | 26 ++
 rtl/ex_alu.sv | 39 +++
 rtl/ex_mem_stage.sv | 179 +++++++++++++++++
 tb/tb_ex_mem_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types and defaults for the execute / EX-MEM stage.
package ex_pkg;

  localparam int EX_DW  = 32;
  localparam int EX_RDW = 6;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_INC    = 4'd2,
    ALU_NEG    = 4'd3,
    ALU_AND    = 4'd4,
    ALU_OR     = 4'd5,
    ALU_PASS_A = 4'd6,
    ALU_PASS_B = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic reg_wrt;
    logic mem_to_reg;
    logic pc_to_reg;
    logic mem_rd;
    logic mem_wrt;
  } exmem_ctrl_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU: result plus Z/N and a flag-write enable for defined ops.
module ex_alu
  import ex_pkg::*;
#(
  parameter int DW = EX_DW
) (
  input  logic [3:0]    alu_op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          n,
  output logic          flag_we
);

  // Operation decode; undefined encodings give zero and leave flags alone.
  always_comb begin
    result  = {DW{1'b0}};
    flag_we = 1'b1;
    case (alu_op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_INC:    result = a + {{(DW-1){1'b0}}, 1'b1};
      ALU_NEG:    result = {DW{1'b0}} - a;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_PASS_A: result = a;
      ALU_PASS_B: result = b;
      default: begin
        result  = {DW{1'b0}};
        flag_we = 1'b0;
      end
    endcase
  end

  assign z = (result == {DW{1'b0}});
  assign n = result[DW-1];

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with Z/N flags, branch redirect and the EX/MEM register.
// Optional EX->EX forwarding is enabled by defining EXMEM_FWD_EN.
module ex_mem_stage
  import ex_pkg::*;
#(
  parameter int DW  = EX_DW,
  parameter int RDW = EX_RDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           stall,
  input  logic           flush,
  input  logic           valid_in,
  input  logic           reg_wrt,
  input  logic           mem_to_reg,
  input  logic           pc_to_reg,
  input  logic           mem_rd,
  input  logic           mem_wrt,
  input  logic           branch_neg,
  input  logic           branch_Zero,
  input  logic           jump,
  input  logic           jump_mem,
  input  logic [3:0]     ALU_op,
  input  logic [DW-1:0]  rs,
  input  logic [DW-1:0]  rt,
  input  logic [RDW-1:0] rd,
  input  logic [DW-1:0]  adder,
  output logic           valid_out,
  output logic           reg_wrt_out,
  output logic           mem_to_reg_out,
  output logic           pc_to_reg_out,
  output logic           mem_rd_out,
  output logic           mem_wrt_out,
  output logic [DW-1:0]  alu_result,
  output logic [DW-1:0]  store_data,
  output logic [RDW-1:0] rd_out,
  output logic [DW-1:0]  adder_out,
  output logic           flag_z,
  output logic           flag_n,
  output logic           redirect,
  output logic [DW-1:0]  redirect_pc,
  output logic           redirect_mem
);

  logic           valid_q, valid_d;
  exmem_ctrl_t    ctrl_q, ctrl_d;
  logic [DW-1:0]  alu_result_q, alu_result_d;
  logic [DW-1:0]  store_data_q, store_data_d;
  logic [RDW-1:0] rd_q, rd_d;
  logic [DW-1:0]  adder_q, adder_d;
  logic           flag_z_q, flag_z_d;
  logic           flag_n_q, flag_n_d;
  logic           redirect_q, redirect_d;
  logic [DW-1:0]  redirect_pc_q, redirect_pc_d;
  logic           redirect_mem_q, redirect_mem_d;
  logic           kill_q, kill_d;

  logic [DW-1:0]  op_a_s, op_b_s, alu_res_s;
  logic           alu_z_s, alu_n_s, alu_we_s;
  logic           accept_s, take_s;

`ifdef EXMEM_FWD_EN
  logic fwd_hit_s;
  assign fwd_hit_s = valid_q & ctrl_q.reg_wrt & ~ctrl_q.mem_to_reg & ~ctrl_q.pc_to_reg
                     & (rd == rd_q);
  assign op_a_s = fwd_hit_s ? alu_result_q : rs;
  assign op_b_s = fwd_hit_s ? alu_result_q : rt;
`else
  assign op_a_s = rs;
  assign op_b_s = rt;
`endif

  ex_alu #(.DW(DW)) u_alu (
    .alu_op  (ALU_op),
    .a       (op_a_s),
    .b       (op_b_s),
    .result  (alu_res_s),
    .z       (alu_z_s),
    .n       (alu_n_s),
    .flag_we (alu_we_s)
  );

  // Branch decision reads the flags held before this edge, so an instruction never steers itself.
  assign accept_s = valid_in & ~stall & ~flush & ~kill_q;
  assign take_s   = jump | jump_mem | (branch_Zero & flag_z_q) | (branch_neg & flag_n_q);

  // Next-state for the EX/MEM register, flags and squash; stall holds everything but the pulse.
  always_comb begin
    valid_d        = valid_q;
    ctrl_d         = ctrl_q;
    alu_result_d   = alu_result_q;
    store_data_d   = store_data_q;
    rd_d           = rd_q;
    adder_d        = adder_q;
    flag_z_d       = flag_z_q;
    flag_n_d       = flag_n_q;
    redirect_d     = redirect_q;
    redirect_pc_d  = redirect_pc_q;
    redirect_mem_d = redirect_mem_q;
    kill_d         = kill_q;
    if (stall) begin
      redirect_d = 1'b0;
    end else begin
      valid_d            = accept_s;
      ctrl_d.reg_wrt     = accept_s & reg_wrt;
      ctrl_d.mem_to_reg  = mem_to_reg;
      ctrl_d.pc_to_reg   = pc_to_reg;
      ctrl_d.mem_rd      = mem_rd;
      ctrl_d.mem_wrt     = accept_s & mem_wrt;
      alu_result_d       = alu_res_s;
      store_data_d       = op_b_s;
      rd_d               = rd;
      adder_d            = adder;
      redirect_d         = accept_s & take_s;
      redirect_mem_d     = accept_s & take_s & jump_mem;
      kill_d             = accept_s & take_s;
      if (accept_s & take_s) begin
        redirect_pc_d = op_a_s;
      end else begin
        redirect_pc_d = redirect_pc_q;
      end
      if (accept_s & alu_we_s & ~mem_rd & ~mem_wrt) begin
        flag_z_d = alu_z_s;
        flag_n_d = alu_n_s;
      end else begin
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= 1'b0;
      ctrl_q         <= '{default: 1'b0};
      alu_result_q   <= {DW{1'b0}};
      store_data_q   <= {DW{1'b0}};
      rd_q           <= {RDW{1'b0}};
      adder_q        <= {DW{1'b0}};
      flag_z_q       <= 1'b0;
      flag_n_q       <= 1'b0;
      redirect_q     <= 1'b0;
      redirect_pc_q  <= {DW{1'b0}};
      redirect_mem_q <= 1'b0;
      kill_q         <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      ctrl_q         <= ctrl_d;
      alu_result_q   <= alu_result_d;
      store_data_q   <= store_data_d;
      rd_q           <= rd_d;
      adder_q        <= adder_d;
      flag_z_q       <= flag_z_d;
      flag_n_q       <= flag_n_d;
      redirect_q     <= redirect_d;
      redirect_pc_q  <= redirect_pc_d;
      redirect_mem_q <= redirect_mem_d;
      kill_q         <= kill_d;
    end
  end

  assign valid_out      = valid_q;
  assign reg_wrt_out    = ctrl_q.reg_wrt;
  assign mem_to_reg_out = ctrl_q.mem_to_reg;
  assign pc_to_reg_out  = ctrl_q.pc_to_reg;
  assign mem_rd_out     = ctrl_q.mem_rd;
  assign mem_wrt_out    = ctrl_q.mem_wrt;
  assign alu_result     = alu_result_q;
  assign store_data     = store_data_q;
  assign rd_out         = rd_q;
  assign adder_out      = adder_q;
  assign flag_z         = flag_z_q;
  assign flag_n         = flag_n_q;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign redirect_mem   = redirect_mem_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a cycle-level reference model queues expectations,
// a negedge monitor compares them; directed spot checks cover the key scenarios.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, valid_in;
  logic        reg_wrt, mem_to_reg, pc_to_reg, mem_rd, mem_wrt;
  logic        branch_neg, branch_Zero, jump, jump_mem;
  logic [3:0]  ALU_op;
  logic [31:0] rs, rt, adder;
  logic [5:0]  rd;
  logic        valid_out, reg_wrt_out, mem_to_reg_out, pc_to_reg_out, mem_rd_out, mem_wrt_out;
  logic [31:0] alu_result, store_data, adder_out, redirect_pc;
  logic [5:0]  rd_out;
  logic        flag_z, flag_n, redirect, redirect_mem;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .reg_wrt(reg_wrt), .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg),
    .mem_rd(mem_rd), .mem_wrt(mem_wrt), .branch_neg(branch_neg),
    .branch_Zero(branch_Zero), .jump(jump), .jump_mem(jump_mem), .ALU_op(ALU_op),
    .rs(rs), .rt(rt), .rd(rd), .adder(adder),
    .valid_out(valid_out), .reg_wrt_out(reg_wrt_out), .mem_to_reg_out(mem_to_reg_out),
    .pc_to_reg_out(pc_to_reg_out), .mem_rd_out(mem_rd_out), .mem_wrt_out(mem_wrt_out),
    .alu_result(alu_result), .store_data(store_data), .rd_out(rd_out),
    .adder_out(adder_out), .flag_z(flag_z), .flag_n(flag_n), .redirect(redirect),
    .redirect_pc(redirect_pc), .redirect_mem(redirect_mem)
  );

  typedef struct packed {
    logic        rst, stall, flush, valid;
    logic        reg_wrt, mem_to_reg, pc_to_reg, mem_rd, mem_wrt;
    logic        bn, bz, jump, jump_mem;
    logic [3:0]  op;
    logic [31:0] rs, rt, adder;
    logic [5:0]  rd;
  } stim_t;

  typedef struct packed {
    logic        valid, reg_wrt, mem_to_reg, pc_to_reg, mem_rd, mem_wrt;
    logic [31:0] alu, store, adder, rpc;
    logic [5:0]  rd;
    logic        fz, fn, redir, rmem;
  } obs_t;

  obs_t exp_q[$];
  obs_t m;          // model's view of every registered output, flags included
  bit   m_kill;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic obs_t sample();
    obs_t o;
    o.valid = valid_out;  o.reg_wrt = reg_wrt_out;  o.mem_to_reg = mem_to_reg_out;
    o.pc_to_reg = pc_to_reg_out;  o.mem_rd = mem_rd_out;  o.mem_wrt = mem_wrt_out;
    o.alu = alu_result;  o.store = store_data;  o.adder = adder_out;  o.rpc = redirect_pc;
    o.rd = rd_out;  o.fz = flag_z;  o.fn = flag_n;  o.redir = redirect;  o.rmem = redirect_mem;
    return o;
  endfunction

  // Reference ALU written straight from the opcode table.
  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        defined;
    defined = (op < 4'd8);
    r = 32'd0;
    if (op == 4'd0) r = a + b;
    if (op == 4'd1) r = a - b;
    if (op == 4'd2) r = a + 32'd1;
    if (op == 4'd3) r = 32'd0 - a;
    if (op == 4'd4) r = a & b;
    if (op == 4'd5) r = a | b;
    if (op == 4'd6) r = a;
    if (op == 4'd7) r = b;
    return {defined, r};
  endfunction

  task automatic model(input stim_t s);
    obs_t        e;
    logic [31:0] a, b;
    logic [32:0] ar;
    bit          acc, take;
    e = m;
    a = s.rs;
    b = s.rt;
    if (s.rst) begin
      e = '0;
      m_kill = 1'b0;
    end else if (s.stall) begin
      e.redir = 1'b0;
    end else begin
`ifdef EXMEM_FWD_EN
      if (m.valid && m.reg_wrt && !m.mem_to_reg && !m.pc_to_reg && s.rd == m.rd) begin
        a = m.alu;
        b = m.alu;
      end
`endif
      acc  = s.valid && !s.flush && !m_kill;
      take = s.jump || s.jump_mem || (s.bz && m.fz) || (s.bn && m.fn);
      ar   = alu_ref(s.op, a, b);
      e.valid = acc;  e.reg_wrt = acc && s.reg_wrt;  e.mem_wrt = acc && s.mem_wrt;
      e.mem_to_reg = s.mem_to_reg;  e.pc_to_reg = s.pc_to_reg;  e.mem_rd = s.mem_rd;
      e.alu = ar[31:0];  e.store = b;  e.adder = s.adder;  e.rd = s.rd;
      e.redir = acc && take;
      e.rmem  = acc && take && s.jump_mem;
      if (acc && take) e.rpc = a;
      if (acc && ar[32] && !s.mem_rd && !s.mem_wrt) begin
        e.fz = (ar[31:0] == 32'd0);
        e.fn = ar[31];
      end
      m_kill = acc && take;
    end
    m = e;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, queue its expectation, and return 1 time unit after the edge.
  task automatic step(input stim_t s);
    rst = s.rst;  stall = s.stall;  flush = s.flush;  valid_in = s.valid;
    reg_wrt = s.reg_wrt;  mem_to_reg = s.mem_to_reg;  pc_to_reg = s.pc_to_reg;
    mem_rd = s.mem_rd;  mem_wrt = s.mem_wrt;  branch_neg = s.bn;  branch_Zero = s.bz;
    jump = s.jump;  jump_mem = s.jump_mem;  ALU_op = s.op;
    rs = s.rs;  rt = s.rt;  adder = s.adder;  rd = s.rd;
    model(s);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    stim_t s;
    s = '0;
    s.valid = 1'b1;  s.reg_wrt = 1'b1;  s.op = op;  s.rs = a;  s.rt = b;
    s.rd = 6'd1;  s.adder = 32'h0000_1000;
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one expectation per clock, compared mid-cycle.
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = sample();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got %h, expected %h", $time, a, e);
      end
    end
  end

  initial begin
    stim_t s;
    m = '0;
    m_kill = 1'b0;
    s = '0;
    s.rst = 1'b1;
    step(s);
    step(s);
    chk("reset_valid", {31'd0, valid_out}, 32'd0);

    // SUB equal operands sets Z, then BRZ redirects and squashes the follower.
    step(mk(4'd1, 32'd5, 32'd5));
    chk("sub_result", alu_result, 32'd0);
    chk("sub_z", {31'd0, flag_z}, 32'd1);
    chk("sub_n", {31'd0, flag_n}, 32'd0);
    s = mk(4'd0, 32'h40, 32'd0);  s.bz = 1'b1;  s.reg_wrt = 1'b0;
    step(s);
    chk("brz_redirect", {31'd0, redirect}, 32'd1);
    chk("brz_pc", redirect_pc, 32'h40);
    step(mk(4'd0, 32'd1, 32'd2));
    chk("killed_valid", {31'd0, valid_out}, 32'd0);
    chk("redirect_pulse", {31'd0, redirect}, 32'd0);

    // Reset while Z is set clears everything.
    step(mk(4'd3, 32'd0, 32'd0));
    s = '0;  s.rst = 1'b1;
    step(s);
    chk("rst_flags", {30'd0, flag_z, flag_n}, 32'd0);

    step(mk(4'd0, 32'h7FFF_FFFF, 32'd1));
    chk("add_ovf", alu_result, 32'h8000_0000);
    chk("add_ovf_nz", {30'd0, flag_n, flag_z}, 32'd2);

    // BRN held under stall for three cycles, then a single pulse on release.
    s = mk(4'd6, 32'h100, 32'd0);  s.bn = 1'b1;  s.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(s);
      chk("stall_redirect", {31'd0, redirect}, 32'd0);
      chk("stall_hold", alu_result, 32'h8000_0000);
    end
    s.stall = 1'b0;
    step(s);
    chk("brn_redirect", {31'd0, redirect}, 32'd1);
    chk("brn_pc", redirect_pc, 32'h100);
    step(mk(4'd0, 32'd7, 32'd7));
    chk("brn_single_pulse", {31'd0, redirect}, 32'd0);

    step(mk(4'd3, 32'd0, 32'd9));
    chk("neg_zero", alu_result, 32'd0);
    chk("neg_z", {31'd0, flag_z}, 32'd1);

    s = mk(4'd0, 32'd3, 32'd4);  s.flush = 1'b1;  s.stall = 1'b1;
    step(s);
    s.flush = 1'b0;  s.stall = 1'b0;
    step(s);
    chk("flush_lost", {31'd0, valid_out}, 32'd1);
    s.flush = 1'b1;
    step(s);
    chk("flush_bubble", {30'd0, valid_out, reg_wrt_out}, 32'd0);

    s = mk(4'd0, 32'd2, 32'd3);  s.rd = 6'd3;
    step(s);
    s = mk(4'd6, 32'd9, 32'd0);  s.rd = 6'd3;
    step(s);
`ifdef EXMEM_FWD_EN
    chk("forward", alu_result, 32'd5);
`else
    chk("no_forward", alu_result, 32'd9);
`endif

    // Reset drops a pending squash/redirect.
    s = mk(4'd0, 32'h200, 32'd0);  s.jump = 1'b1;
    step(s);
    s = '0;  s.rst = 1'b1;
    step(s);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    step(mk(4'd4, 32'hF0F0, 32'h0FF0));
    chk("rst_clears_kill", {31'd0, valid_out}, 32'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      s = '0;
      s.rst        = ($urandom_range(0, 49) == 0);
      s.stall      = ($urandom_range(0, 6) == 0);
      s.flush      = ($urandom_range(0, 9) == 0);
      s.valid      = ($urandom_range(0, 7) != 0);
      s.reg_wrt    = $urandom_range(0, 1);
      s.mem_to_reg = $urandom_range(0, 1);
      s.pc_to_reg  = ($urandom_range(0, 3) == 0);
      s.mem_rd     = ($urandom_range(0, 4) == 0);
      s.mem_wrt    = ($urandom_range(0, 4) == 0);
      s.bn         = ($urandom_range(0, 5) == 0);
      s.bz         = ($urandom_range(0, 5) == 0);
      s.jump       = ($urandom_range(0, 15) == 0);
      s.jump_mem   = ($urandom_range(0, 15) == 0);
      s.op         = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      s.rs         = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      s.rt         = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : 32'($urandom);
      s.rd         = 6'($urandom_range(0, 3));
      s.adder      = $urandom;
      step(s);
    end

    s = '0;
    step(s);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
